// File: rtl/trigger_power_detect.sv
// Windowed sum-of-squares power detector with thresholded, holdoff-limited trigger.
// Define TRIG_PEAK_CAPTURE_EN to add peak_clr_i / peak_o peak-power capture.
module trigger_power_detect #(
   parameter int unsigned NSAMP    = 8,
   parameter int unsigned NBITS    = 12,
   parameter int unsigned WIN_LOG2 = 2,
   parameter int unsigned HOLDOFF  = 64
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NSAMP*NBITS-1:0]   dat_i,
   input  logic                     dat_valid_i,
   input  logic                     enable_i,
   input  logic [31:0]              threshold_i,
   output logic [31:0]              power_o,
   output logic                     power_valid_o,
   output logic                     trig_o,
   output logic [15:0]              trig_count_o
`ifdef TRIG_PEAK_CAPTURE_EN
   ,
   input  logic                     peak_clr_i,
   output logic [31:0]              peak_o
`endif
);

   localparam int unsigned SQW   = 2*NBITS - 1;
   localparam int unsigned BSW   = SQW + $clog2(NSAMP);
   localparam int unsigned WSW   = BSW + WIN_LOG2;
   localparam int unsigned DEPTH = 1 << WIN_LOG2;
   localparam int unsigned PW    = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
   localparam int unsigned FW    = WIN_LOG2 + 1;

   typedef enum logic [0:0] {ST_ARMED, ST_HOLDOFF} state_t;

   logic [NSAMP*NBITS-1:0] dat_q, dat_d;
   logic                   vld0_q, vld0_d, vld1_q, vld1_d, vld2_q, vld2_d;
   logic [SQW-1:0]         sq_q [NSAMP];
   logic [SQW-1:0]         sq_d [NSAMP];
   logic [BSW-1:0]         bsum_q, bsum_d;
   logic [BSW-1:0]         hist_q [DEPTH];
   logic [BSW-1:0]         hist_d [DEPTH];
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [FW-1:0]          fill_q, fill_d;
   logic [WSW-1:0]         wsum_q, wsum_d;
   logic                   pvalid_q, pvalid_d;
   state_t                 state_q, state_d;
   logic [15:0]            hold_q, hold_d;
   logic                   trig_q, trig_d;
   logic [15:0]            count_q, count_d;
   logic                   above;
   logic [NBITS-1:0]       raw;
   logic [SQW-1:0]         mag;

   // Squares come from the magnitude so every product bit is meaningful (|-2048| still fits NBITS).
   always_comb begin
      dat_d  = dat_i;
      vld0_d = dat_valid_i;
      vld1_d = vld0_q;
      vld2_d = vld1_q;
      raw    = '0;
      mag    = '0;
      for (int unsigned k = 0; k < NSAMP; k++) begin
         raw     = dat_q[k*NBITS +: NBITS];
         mag     = raw[NBITS-1] ? SQW'(~raw + 1'b1) : SQW'(raw);
         sq_d[k] = mag * mag;
      end
      bsum_d = '0;
      for (int unsigned k = 0; k < NSAMP; k++) begin
         bsum_d = bsum_d + BSW'(sq_q[k]);
      end
   end

   always_comb begin
      hist_d   = hist_q;
      ptr_d    = ptr_q;
      fill_d   = fill_q;
      wsum_d   = wsum_q;
      pvalid_d = 1'b0;
      if (vld2_q) begin
         hist_d[ptr_q] = bsum_q;
         wsum_d        = wsum_q + WSW'(bsum_q) - WSW'(hist_q[ptr_q]);
         ptr_d         = (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
         if (fill_q != FW'(DEPTH)) fill_d = fill_q + 1'b1;
         pvalid_d      = (fill_q >= FW'(DEPTH-1));
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         dat_q    <= '0;
         vld0_q   <= 1'b0;
         vld1_q   <= 1'b0;
         vld2_q   <= 1'b0;
         bsum_q   <= '0;
         ptr_q    <= '0;
         fill_q   <= '0;
         wsum_q   <= '0;
         pvalid_q <= 1'b0;
         for (int unsigned i = 0; i < NSAMP; i++) sq_q[i] <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      end else begin
         dat_q    <= dat_d;
         vld0_q   <= vld0_d;
         vld1_q   <= vld1_d;
         vld2_q   <= vld2_d;
         bsum_q   <= bsum_d;
         ptr_q    <= ptr_d;
         fill_q   <= fill_d;
         wsum_q   <= wsum_d;
         pvalid_q <= pvalid_d;
         sq_q     <= sq_d;
         hist_q   <= hist_d;
      end
   end

   assign power_o       = 32'(wsum_q);
   assign power_valid_o = pvalid_q;

   // Holdoff is loaded with HOLDOFF-1 so back-to-back pulses land HOLDOFF+1 clocks apart.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      trig_d  = 1'b0;
      above   = pvalid_q && (power_o > threshold_i);
      if (!enable_i) begin
         state_d = ST_ARMED;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (above) begin
                  trig_d  = 1'b1;
                  state_d = ST_HOLDOFF;
                  hold_d  = 16'(HOLDOFF - 1);
               end
            end
            ST_HOLDOFF: begin
               if (hold_q == '0) state_d = ST_ARMED;
               else              hold_d  = hold_q - 1'b1;
            end
            default: state_d = ST_ARMED;
         endcase
      end
      count_d = (trig_d && (count_q != '1)) ? count_q + 1'b1 : count_q;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= ST_ARMED;
         hold_q  <= '0;
         trig_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         trig_q  <= trig_d;
         count_q <= count_d;
      end
   end

   assign trig_o       = trig_q;
   assign trig_count_o = count_q;

`ifdef TRIG_PEAK_CAPTURE_EN
   logic [31:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (peak_clr_i)                         peak_d = pvalid_q ? power_o : '0;
      else if (pvalid_q && power_o > peak_q)  peak_d = power_o;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) peak_q <= '0;
      else          peak_q <= peak_d;
   end

   assign peak_o = peak_q;
`endif

endmodule
